// File: rtl/tea_output_collector.sv
// Collects 64-bit TEA scheduler blocks after a pipeline-fill phase and serializes them as 32-bit words.
// Define TEA_COLLECTOR_BSWAP_EN to byte-reverse every output word.
module tea_output_collector #(
  parameter int FILL_CYCLES = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [63:0] inBlock64,
  output logic [31:0] outWord32,
  output logic        outValid,
  input  logic        outReady,
  output logic        fillDone,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {FILL, RUN} state_t;

  state_t      state, state_nxt;
  logic [7:0]  fill_cnt, fill_cnt_nxt;
  logic        capture;

  logic [63:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic        half, half_nxt;
  logic        empty, full, xfer, pop, wr_en, drop;
  logic [63:0] entry_nxt;
  logic [31:0] word_raw, word_nxt;

  function automatic logic [31:0] byte_order(input logic [31:0] w);
`ifdef TEA_COLLECTOR_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  always_comb begin
    state_nxt    = state;
    fill_cnt_nxt = fill_cnt;
    capture      = 1'b0;
    case (state)
      FILL: begin
        if (FILL_CYCLES == 0) begin
          state_nxt = RUN;
          capture   = ena;
        end else if (ena) begin
          fill_cnt_nxt = fill_cnt + 8'd1;
          if (fill_cnt_nxt == 8'(FILL_CYCLES)) state_nxt = RUN;
        end
      end
      RUN: capture = ena;
      default: state_nxt = FILL;
    endcase
  end

  // Extra MSB on each pointer separates full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign outValid = !empty;
  assign fillDone = (state == RUN);

  assign xfer  = outValid && outReady;
  assign pop   = xfer && half;
  assign wr_en = capture && (!full || pop);
  assign drop  = capture && full && !pop;

  assign rd_nxt   = rd_ptr + {{AW{1'b0}}, pop};
  assign wr_nxt   = wr_ptr + {{AW{1'b0}}, wr_en};
  assign half_nxt = xfer ? ~half : half;

  // When the block being written becomes the new head, take it straight from the input.
  always_comb begin
    entry_nxt = mem[rd_nxt[AW-1:0]];
    if (wr_en && (rd_nxt == wr_ptr)) entry_nxt = inBlock64;
    word_raw = half_nxt ? entry_nxt[31:0] : entry_nxt[63:32];
    word_nxt = (rd_nxt == wr_nxt) ? 32'd0 : byte_order(word_raw);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= FILL;
      fill_cnt  <= 8'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      half      <= 1'b0;
      overflow  <= 1'b0;
      outWord32 <= 32'd0;
    end else begin
      state     <= state_nxt;
      fill_cnt  <= fill_cnt_nxt;
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      half      <= half_nxt;
      overflow  <= overflow || drop;
      outWord32 <= word_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= inBlock64;
  end

endmodule

// File: tb/tb_tea_output_collector.sv
// Directed bench for tea_output_collector; expected words follow TEA_COLLECTOR_BSWAP_EN when defined.
module tb_tea_output_collector;

  logic        clk = 1'b0;
  logic        rst, ena, outReady;
  logic [63:0] inBlock64;
  logic [31:0] outWord32;
  logic        outValid, fillDone, overflow;

  int checks = 0;
  int errors = 0;

  tea_output_collector #(.FILL_CYCLES(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .inBlock64(inBlock64),
    .outWord32(outWord32), .outValid(outValid), .outReady(outReady),
    .fillDone(fillDone), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bs(input logic [31:0] w);
`ifdef TEA_COLLECTOR_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [63:0] b, input logic rd);
    rst = r; ena = e; inBlock64 = b; outReady = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic fill32();
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 64'hDEADBEEF_DEADBEEF, 1'b1);
  endtask

  logic [31:0] exp_q[$];
  int en_cnt;

  initial begin
    rst = 1'b0; ena = 1'b0; inBlock64 = '0; outReady = 1'b0;
    step(1'b0, 1'b0, 64'd0, 1'b0);
    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    check("rst_valid", outValid, 0);
    check("rst_word", outWord32, 0);
    check("rst_filldone", fillDone, 0);
    check("rst_overflow", overflow, 0);

    // Fill with ena alternating: done only after 32 enabled cycles.
    en_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      step(1'b1, (i % 2) == 0, 64'hDEADBEEF_DEADBEEF, 1'b1);
      if ((i % 2) == 0) en_cnt++;
      check("fill_valid", outValid, 0);
      check("fill_done", fillDone, (en_cnt >= 32) ? 1 : 0);
    end
    step(1'b1, 1'b1, 64'h01234567_89ABCDEF, 1'b1);
    check("first_valid", outValid, 1);
    check("first_hi", outWord32, bs(32'h01234567));
    step(1'b1, 1'b0, 64'd0, 1'b1);
    check("first_lo", outWord32, bs(32'h89ABCDEF));
    check("first_lo_valid", outValid, 1);
    step(1'b1, 1'b0, 64'd0, 1'b1);
    check("drained_valid", outValid, 0);
    check("no_overflow", overflow, 0);

    // Stall the consumer and overfill.
    for (int b = 1; b <= 5; b++) begin
      step(1'b1, 1'b1, 64'(b), 1'b0);
      check("stall_valid", outValid, 1);
      check("stall_word", outWord32, bs(32'd0));
      check("stall_overflow", overflow, (b == 5) ? 1 : 0);
    end
    for (int b = 1; b <= 4; b++) begin
      exp_q.push_back(bs(32'd0));
      exp_q.push_back(bs(32'(b)));
    end
    while (exp_q.size() > 0) begin
      check("drain_word", outWord32, exp_q.pop_front());
      check("drain_valid", outValid, 1);
      step(1'b1, 1'b0, 64'd0, 1'b1);
    end
    check("drain_empty", outValid, 0);
    check("overflow_sticky", overflow, 1);

    // Write accepted when full if the head pops in the same cycle.
    step(1'b0, 1'b0, 64'd0, 1'b0);
    check("rst2_overflow", overflow, 0);
    fill32();
    for (int b = 5; b <= 8; b++) step(1'b1, 1'b1, 64'(b), 1'b0);
    step(1'b1, 1'b0, 64'd0, 1'b1);
    check("full_lo", outWord32, bs(32'd5));
    step(1'b1, 1'b1, 64'd9, 1'b1);
    check("pop_write_overflow", overflow, 0);
    for (int b = 6; b <= 9; b++) begin
      exp_q.push_back(bs(32'd0));
      exp_q.push_back(bs(32'(b)));
    end
    while (exp_q.size() > 0) begin
      check("pw_word", outWord32, exp_q.pop_front());
      step(1'b1, 1'b0, 64'd0, 1'b1);
    end
    check("pw_empty", outValid, 0);
    check("pw_overflow", overflow, 0);

    // Mid-operation reset discards buffered data.
    for (int b = 10; b <= 12; b++) step(1'b1, 1'b1, 64'(b) | 64'hAB00_0000_0000_0000, 1'b0);
    step(1'b1, 1'b0, 64'd0, 1'b1);
    check("pre_rst_word", outWord32, bs(32'd10));
    step(1'b0, 1'b1, 64'h5555_5555_5555_5555, 1'b1);
    check("midrst_valid", outValid, 0);
    check("midrst_word", outWord32, 0);
    check("midrst_filldone", fillDone, 0);
    check("midrst_overflow", overflow, 0);
    step(1'b1, 1'b1, 64'h7777_7777_7777_7777, 1'b1);
    check("refill_valid", outValid, 0);
    check("refill_done", fillDone, 0);
    for (int i = 0; i < 31; i++) step(1'b1, 1'b1, 64'hDEADBEEF_DEADBEEF, 1'b1);
    check("refill_done2", fillDone, 1);
    check("refill_valid2", outValid, 0);

    // Byte-order pattern.
    step(1'b1, 1'b1, 64'h11223344_55667788, 1'b1);
    check("bs_hi", outWord32, bs(32'h11223344));
    step(1'b1, 1'b0, 64'd0, 1'b1);
    check("bs_lo", outWord32, bs(32'h55667788));
    step(1'b1, 1'b0, 64'd0, 1'b1);
    check("bs_empty", outValid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
